// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the 8-bit accumulator CPU.
// Steps each instruction through fetch/decode/exec-or-mem/write-back with one-cycle strobes.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for run or step, no strobes
// FETCH  | instruction read from PC address, ir_load on mem_ready
// DECODE | regBuf capture, choose EXEC or MEM from ctl_mem_sc
// EXEC   | ALU settles, no strobes
// MEM    | data access at acc_out address, store when ctl_memWE
// WB     | accum/shiftregs write, PC increment or branch, retire
// FAULT  | memory timeout, sticky until rst_n
module cpu_sequencer #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             step,
  input  logic             ctl_regWE,
  input  logic             ctl_accWE,
  input  logic             ctl_memWE,
  input  logic             ctl_mem_sc,
  input  logic             ctl_brnch,
  input  logic             acc_nz,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_load,
  output logic             regbuf_load,
  output logic             acc_we,
  output logic             reg_we,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             busy,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd7;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [7:0]       r_wait;
  logic             r_single;
  logic [CNT_W-1:0] r_count;
  logic             w_waiting;
  logic             w_tmo;

  assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_tmo     = w_waiting && !mem_ready && (r_wait == TMO);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (run || step) w_next = S_FETCH;
      S_FETCH: begin
        if (mem_ready)  w_next = S_DECODE;
        else if (w_tmo) w_next = S_FAULT;
      end
      S_DECODE: w_next = ctl_mem_sc ? S_MEM : S_EXEC;
      S_EXEC:   w_next = S_WB;
      S_MEM: begin
        if (mem_ready)  w_next = S_WB;
        else if (w_tmo) w_next = S_FAULT;
      end
      S_WB:     w_next = (r_single || !run) ? S_IDLE : S_FETCH;
      S_FAULT:  w_next = S_FAULT;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_wait   <= 8'd0;
      r_single <= 1'b0;
      r_count  <= '0;
    end else begin
      r_state <= w_next;

      // Counter restarts whenever a memory-wait state is newly entered.
      if ((w_next != r_state) && ((w_next == S_FETCH) || (w_next == S_MEM)))
        r_wait <= 8'd0;
      else if (w_waiting && !mem_ready)
        r_wait <= r_wait + 8'd1;

      if (r_state == S_IDLE) begin
        if (run)       r_single <= 1'b0;
        else if (step) r_single <= 1'b1;
      end else if ((r_state == S_WB) && (w_next == S_IDLE)) begin
        r_single <= 1'b0;
      end

      if (r_state == S_WB)
        r_count <= r_count + CNT_W'(1);
    end
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_load      = 1'b0;
    regbuf_load  = 1'b0;
    acc_we       = 1'b0;
    reg_we       = 1'b0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_load = mem_ready;
      end
      S_DECODE: regbuf_load = 1'b1;
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = ctl_memWE;
      end
      S_WB: begin
        acc_we  = ctl_accWE;
        reg_we  = ctl_regWE;
        pc_load = ctl_brnch & acc_nz;
        pc_inc  = ~(ctl_brnch & acc_nz);
      end
      default: ;
    endcase
  end

  assign busy        = (r_state != S_IDLE) && (r_state != S_FAULT);
  assign fault       = (r_state == S_FAULT);
  assign state       = r_state;
  assign instr_count = r_count;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: free-run, single-step, branch, wait states,
// timeout fault, async reset mid-access and retired-count wrap (CNT_W=4).
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run, step;
  logic       ctl_regWE, ctl_accWE, ctl_memWE, ctl_mem_sc, ctl_brnch, acc_nz;
  logic       mem_ready;
  logic       mem_req, mem_we, mem_addr_sel, ir_load, regbuf_load;
  logic       acc_we, reg_we, pc_inc, pc_load, busy, fault;
  logic [2:0] state;
  logic [3:0] instr_count;

  int checks = 0;
  int errors = 0;

  cpu_sequencer #(.CNT_W(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step),
    .ctl_regWE(ctl_regWE), .ctl_accWE(ctl_accWE), .ctl_memWE(ctl_memWE),
    .ctl_mem_sc(ctl_mem_sc), .ctl_brnch(ctl_brnch), .acc_nz(acc_nz),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_load(ir_load), .regbuf_load(regbuf_load),
    .acc_we(acc_we), .reg_we(reg_we), .pc_inc(pc_inc), .pc_load(pc_load),
    .busy(busy), .fault(fault), .state(state), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; run = 0; step = 0;
    ctl_regWE = 0; ctl_accWE = 0; ctl_memWE = 0; ctl_mem_sc = 0; ctl_brnch = 0;
    acc_nz = 0; mem_ready = 0;
    #1;
    chk("rst_state", state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fault", fault, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_memreq", mem_req, 0);
    cyc(); cyc();
    rst_n = 1'b1;

    // free-run ALU op
    ctl_accWE = 1; mem_ready = 1; run = 1;
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk("alu_fetch", state, 1);
      chk("alu_irload", ir_load, 1);
      chk("alu_accwe_f", acc_we, 0);
      cyc();
      chk("alu_decode", state, 2);
      chk("alu_regbuf", regbuf_load, 1);
      cyc();
      chk("alu_exec", state, 3);
      chk("alu_accwe_e", acc_we, 0);
      chk("alu_pcinc_e", pc_inc, 0);
      cyc();
      chk("alu_wb", state, 5);
      chk("alu_accwe_wb", acc_we, 1);
      chk("alu_pcinc_wb", pc_inc, 1);
      chk("alu_pcload_wb", pc_load, 0);
      if (i == 2) run = 0;
      cyc();
    end
    chk("alu_idle", state, 0);
    chk("alu_count", instr_count, 3);

    // single-step store
    ctl_accWE = 0; ctl_mem_sc = 1; ctl_memWE = 1;
    step = 1; cyc(); step = 0;
    chk("st_fetch", state, 1);
    cyc();
    chk("st_decode", state, 2);
    step = 1;
    cyc();
    chk("st_mem", state, 4);
    chk("st_memreq", mem_req, 1);
    chk("st_memwe", mem_we, 1);
    chk("st_addrsel", mem_addr_sel, 1);
    step = 0;
    cyc();
    chk("st_wb", state, 5);
    chk("st_accwe", acc_we, 0);
    cyc();
    chk("st_idle", state, 0);
    chk("st_count", instr_count, 4);
    cyc();
    chk("st_stay_idle", state, 0);

    // branch taken / not taken
    ctl_mem_sc = 0; ctl_memWE = 0; ctl_brnch = 1; acc_nz = 1;
    step = 1; cyc(); step = 0; cyc(); cyc(); cyc();
    chk("br_wb", state, 5);
    chk("br_pcload", pc_load, 1);
    chk("br_pcinc", pc_inc, 0);
    cyc();
    acc_nz = 0;
    step = 1; cyc(); step = 0; cyc(); cyc(); cyc();
    chk("nbr_pcload", pc_load, 0);
    chk("nbr_pcinc", pc_inc, 1);
    cyc();
    chk("br_count", instr_count, 6);

    // three fetch wait states
    ctl_brnch = 0; mem_ready = 0;
    step = 1; cyc(); step = 0;
    chk("w3_fetch1", state, 1);
    chk("w3_irload1", ir_load, 0);
    cyc(); cyc();
    chk("w3_fetch3", state, 1);
    chk("w3_irload3", ir_load, 0);
    cyc();
    mem_ready = 1; #1;
    chk("w3_irload4", ir_load, 1);
    cyc();
    chk("w3_decode", state, 2);
    cyc(); cyc(); cyc();
    chk("w3_count", instr_count, 7);

    // 15 wait states is the last that still progresses
    mem_ready = 0;
    step = 1; cyc(); step = 0;
    for (int k = 1; k <= 15; k++) begin
      chk("w15_fetch", state, 1);
      cyc();
    end
    mem_ready = 1; #1;
    chk("w15_edge_state", state, 1);
    chk("w15_edge_irload", ir_load, 1);
    cyc();
    chk("w15_decode", state, 2);
    cyc(); cyc(); cyc();
    chk("w15_count", instr_count, 8);

    // 16 wait states -> fault
    mem_ready = 0;
    step = 1; cyc(); step = 0;
    for (int k = 1; k <= 16; k++) begin
      chk("tmo_fetch", state, 1);
      chk("tmo_busy", busy, 1);
      cyc();
    end
    chk("tmo_state", state, 7);
    chk("tmo_fault", fault, 1);
    chk("tmo_busy0", busy, 0);
    chk("tmo_memreq", mem_req, 0);
    step = 1; run = 1; mem_ready = 1;
    cyc(); cyc();
    chk("tmo_sticky", state, 7);
    rst_n = 0; #1;
    chk("tmo_rst_state", state, 0);
    chk("tmo_rst_fault", fault, 0);
    chk("tmo_rst_count", instr_count, 0);

    // run+step together, then run dropped in MEM
    cyc();
    run = 1; step = 1; ctl_mem_sc = 1; ctl_memWE = 1;
    rst_n = 1;
    cyc(); step = 0;
    chk("rs_fetch", state, 1);
    cyc(); cyc();
    chk("rs_mem", state, 4);
    cyc();
    chk("rs_wb", state, 5);
    cyc();
    chk("rs_refetch", state, 1);
    cyc(); cyc();
    chk("rs_mem2", state, 4);
    run = 0;
    cyc();
    chk("rs_wb2", state, 5);
    cyc();
    chk("rs_idle", state, 0);
    chk("rs_count", instr_count, 2);

    // async reset while storing
    run = 1;
    cyc(); cyc(); cyc();
    chk("ar_mem", state, 4);
    chk("ar_memwe", mem_we, 1);
    #1 rst_n = 0;
    #1;
    chk("ar_memwe0", mem_we, 0);
    chk("ar_memreq0", mem_req, 0);
    chk("ar_state", state, 0);
    chk("ar_count", instr_count, 0);
    run = 0; ctl_mem_sc = 0; ctl_memWE = 0;
    cyc();
    rst_n = 1;

    // 16 ALU instructions wrap the 4-bit counter
    ctl_accWE = 1; mem_ready = 1; run = 1;
    cyc();
    repeat (60) cyc();
    chk("wrap_fetch", state, 1);
    chk("wrap_count15", instr_count, 15);
    cyc(); cyc(); cyc();
    chk("wrap_wb", state, 5);
    run = 0;
    cyc();
    chk("wrap_idle", state, 0);
    chk("wrap_count0", instr_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
